mode_selector: RTL and testbench

Parametrised run/idle mode and one-hot field selector for the bottling control panel. It tracks the machine's run state and a fault lock-out. It also maintains which of N_SEL display/edit fields is selected, with forward/backward stepping and hold-to-repeat. It sits between the debounced panel-button front end and the display/parameter-edit logic, and exposes the selection as both one-hot and binary index.

---
 rtl/mode_selector.sv | 139 +++++++++++++
 tb/tb_mode_selector.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mode_selector.sv
// Run/idle/fault mode tracker with a one-hot field selector for the bottling panel.
// Field stepping supports wrap within the mode's active range and hold-to-repeat.
module mode_selector #(
    parameter int unsigned N_SEL         = 5,
    parameter int unsigned N_IDLE        = 2,
    parameter int unsigned RESET_IDX     = 1,
    parameter int unsigned REPEAT_DELAY  = 8,
    parameter int unsigned REPEAT_PERIOD = 4,
    localparam int unsigned IW = (N_SEL > 1) ? $clog2(N_SEL) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flip_working,
    input  logic             shift_fwd,
    input  logic             shift_back,
    input  logic             fault,
    input  logic             fault_clear,
    output logic             working,
    output logic             faulted,
    output logic [N_SEL-1:0] selection,
    output logic [IW-1:0]    sel_index,
    output logic             sel_changed
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CW   = $clog2(RMAX + 1);

    localparam logic [N_SEL-1:0] ONE_HOT_0 = {{(N_SEL-1){1'b0}}, 1'b1};
    localparam logic [N_SEL-1:0] RESET_SEL = ONE_HOT_0 << RESET_IDX;

    logic [1:0]       state_q, state_d;
    logic             fwd_q, back_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rep_q, rep_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_SEL-1:0] sel_q;
    logic             chg_q;
    logic             working_q, faulted_q;

    logic             rise_fwd, rise_back, one_held;
    logic             step_fwd, step_back;
    logic [31:0]      range, cur, nxt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fault) state_d = ST_FAULT;
                      else if (flip_working) state_d = ST_RUN;
            ST_RUN:   if (fault) state_d = ST_FAULT;
                      else if (flip_working) state_d = ST_IDLE;
            ST_FAULT: if (fault_clear && !fault) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign rise_fwd  = shift_fwd  & ~fwd_q;
    assign rise_back = shift_back & ~back_q;
    assign one_held  = shift_fwd ^ shift_back;

    // cnt_q counts cycles since the last step while exactly one button is held; 0 means inactive.
    always_comb begin
        step_fwd  = 1'b0;
        step_back = 1'b0;
        cnt_d     = cnt_q;
        rep_d     = rep_q;
        if (!one_held) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (rise_fwd || rise_back) begin
            step_fwd  = rise_fwd;
            step_back = rise_back;
            cnt_d     = CW'(1);
            rep_d     = 1'b0;
        end else if (cnt_q != '0) begin
            if (rep_q ? (cnt_q == CW'(REPEAT_PERIOD)) : (cnt_q == CW'(REPEAT_DELAY))) begin
                step_fwd  = shift_fwd;
                step_back = shift_back;
                cnt_d     = CW'(1);
                rep_d     = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Step within the next state's range, then clamp into the idle range when not running.
    always_comb begin
        range = (state_d == ST_RUN) ? 32'(N_SEL) : 32'(N_IDLE);
        cur   = 32'(idx_q);
        nxt   = cur;
        if (step_fwd) begin
            nxt = (cur == range - 32'd1) ? 32'd0 : cur + 32'd1;
        end else if (step_back) begin
            nxt = (cur == 32'd0) ? range - 32'd1 : cur - 32'd1;
        end
        if (state_d != ST_RUN && nxt >= 32'(N_IDLE)) begin
            nxt = 32'(N_IDLE) - 32'd1;
        end
        idx_d = IW'(nxt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            // History starts as "held" so a button held through reset is not seen as an edge.
            fwd_q     <= 1'b1;
            back_q    <= 1'b1;
            cnt_q     <= '0;
            rep_q     <= 1'b0;
            idx_q     <= IW'(RESET_IDX);
            sel_q     <= RESET_SEL;
            chg_q     <= 1'b0;
            working_q <= 1'b0;
            faulted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fwd_q     <= shift_fwd;
            back_q    <= shift_back;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            idx_q     <= idx_d;
            sel_q     <= ONE_HOT_0 << idx_d;
            chg_q     <= (idx_d != idx_q);
            working_q <= (state_d == ST_RUN);
            faulted_q <= (state_d == ST_FAULT);
        end
    end

    assign working     = working_q;
    assign faulted     = faulted_q;
    assign selection   = sel_q;
    assign sel_index   = idx_q;
    assign sel_changed = chg_q;

endmodule

// File: tb/tb_mode_selector.sv
// Directed bench for mode_selector: a cycle-by-cycle vector table plus hand sequences
// for hold-through-reset, auto-repeat and asynchronous reset mid-repeat.
module tb_mode_selector;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flip_working = 1'b0;
    logic       shift_fwd = 1'b0;
    logic       shift_back = 1'b0;
    logic       fault = 1'b0;
    logic       fault_clear = 1'b0;
    logic       working, faulted, sel_changed;
    logic [4:0] selection;
    logic [2:0] sel_index;

    int total = 0;
    int bad   = 0;

    mode_selector dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flip_working (flip_working),
        .shift_fwd    (shift_fwd),
        .shift_back   (shift_back),
        .fault        (fault),
        .fault_clear  (fault_clear),
        .working      (working),
        .faulted      (faulted),
        .selection    (selection),
        .sel_index    (sel_index),
        .sel_changed  (sel_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       flip, fwd, back, flt, clr;
        logic       e_work, e_flt;
        logic [2:0] e_idx;
        logic       e_chg;
    } vec_t;

    vec_t vecs[41];

    task automatic check(input string name, input logic e_work, input logic e_flt,
                         input logic [2:0] e_idx, input logic e_chg);
        logic [4:0] e_sel;
        e_sel = 5'b00001 << e_idx;
        total++;
        if (working !== e_work || faulted !== e_flt || sel_index !== e_idx ||
            selection !== e_sel || sel_changed !== e_chg) begin
            bad++;
            $display("FAIL %s: got work=%b flt=%b idx=%0d sel=%b chg=%b, want work=%b flt=%b idx=%0d sel=%b chg=%b",
                     name, working, faulted, sel_index, selection, sel_changed,
                     e_work, e_flt, e_idx, e_sel, e_chg);
        end
    endtask

    task automatic set_in(input logic f, input logic fw, input logic bk, input logic ft,
                          input logic cl);
        flip_working = f;
        shift_fwd    = fw;
        shift_back   = bk;
        fault        = ft;
        fault_clear  = cl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic f, input logic fw, input logic bk, input logic ft,
                                input logic cl, input logic w, input logic fl,
                                input logic [2:0] i, input logic c);
        vec_t v;
        v.flip = f; v.fwd = fw; v.back = bk; v.flt = ft; v.clr = cl;
        v.e_work = w; v.e_flt = fl; v.e_idx = i; v.e_chg = c;
        return v;
    endfunction

    initial begin
        // Table starts in IDLE at index 0.
        //            flip fwd back flt clr  work flt idx chg
        vecs[0]  = mk(1, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0,  1, 0, 1, 1);
        vecs[2]  = mk(0, 0, 0, 0, 0,  1, 0, 1, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0,  1, 0, 2, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0,  1, 0, 2, 0);
        vecs[5]  = mk(0, 1, 0, 0, 0,  1, 0, 3, 1);
        vecs[6]  = mk(0, 0, 0, 0, 0,  1, 0, 3, 0);
        vecs[7]  = mk(0, 1, 0, 0, 0,  1, 0, 4, 1);
        vecs[8]  = mk(0, 0, 0, 0, 0,  1, 0, 4, 0);
        vecs[9]  = mk(0, 1, 0, 0, 0,  1, 0, 0, 1);
        vecs[10] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[11] = mk(0, 0, 1, 0, 0,  1, 0, 4, 1);
        vecs[12] = mk(0, 0, 0, 0, 0,  1, 0, 4, 0);
        vecs[13] = mk(0, 0, 1, 0, 0,  1, 0, 3, 1);
        vecs[14] = mk(0, 0, 0, 0, 0,  1, 0, 3, 0);
        vecs[15] = mk(1, 0, 0, 0, 0,  0, 0, 1, 1);
        vecs[16] = mk(1, 0, 0, 0, 0,  1, 0, 1, 0);
        vecs[17] = mk(0, 1, 0, 0, 0,  1, 0, 2, 1);
        vecs[18] = mk(0, 0, 0, 0, 0,  1, 0, 2, 0);
        vecs[19] = mk(0, 1, 0, 0, 0,  1, 0, 3, 1);
        vecs[20] = mk(0, 0, 0, 0, 0,  1, 0, 3, 0);
        vecs[21] = mk(0, 1, 0, 0, 0,  1, 0, 4, 1);
        vecs[22] = mk(0, 0, 0, 0, 0,  1, 0, 4, 0);
        vecs[23] = mk(1, 1, 0, 0, 0,  0, 0, 1, 1);
        vecs[24] = mk(0, 0, 0, 0, 0,  0, 0, 1, 0);
        vecs[25] = mk(0, 1, 0, 0, 0,  0, 0, 0, 1);
        vecs[26] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[27] = mk(0, 1, 1, 0, 0,  0, 0, 0, 0);
        vecs[28] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[29] = mk(1, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[30] = mk(0, 0, 1, 0, 0,  1, 0, 4, 1);
        vecs[31] = mk(0, 0, 0, 0, 0,  1, 0, 4, 0);
        vecs[32] = mk(0, 0, 0, 1, 0,  0, 1, 1, 1);
        vecs[33] = mk(1, 0, 0, 1, 0,  0, 1, 1, 0);
        vecs[34] = mk(0, 0, 0, 1, 1,  0, 1, 1, 0);
        vecs[35] = mk(0, 1, 0, 1, 0,  0, 1, 0, 1);
        vecs[36] = mk(0, 0, 0, 0, 0,  0, 1, 0, 0);
        vecs[37] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0);
        vecs[38] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[39] = mk(1, 0, 0, 1, 0,  0, 1, 0, 0);
        vecs[40] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0);

        // Reset, with shift_fwd held through deassertion.
        set_in(0, 1, 0, 0, 0);
        #12;
        check("reset_vals", 0, 0, 3'd1, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_thru_reset", 0, 0, 3'd1, 0);
        end
        set_in(0, 0, 0, 0, 0);
        tick();
        check("release_after_reset", 0, 0, 3'd1, 0);
        set_in(0, 1, 0, 0, 0);
        tick();
        check("repress_idle_wrap", 0, 0, 3'd0, 1);
        set_in(0, 0, 0, 0, 0);
        tick();
        check("repress_release", 0, 0, 3'd0, 0);

        for (int i = 0; i < 41; i++) begin
            set_in(vecs[i].flip, vecs[i].fwd, vecs[i].back, vecs[i].flt, vecs[i].clr);
            tick();
            check($sformatf("vec%0d", i), vecs[i].e_work, vecs[i].e_flt, vecs[i].e_idx,
                  vecs[i].e_chg);
        end

        // Auto-repeat in RUN from index 0: steps at cycles 0, 8, 12, 16.
        set_in(1, 0, 0, 0, 0);
        tick();
        check("rep_enter_run", 1, 0, 3'd0, 0);
        begin
            logic [2:0] e_idx;
            logic       e_chg;
            e_idx = 3'd0;
            for (int j = 0; j < 20; j++) begin
                set_in(0, 1, 0, 0, 0);
                e_chg = (j == 0 || j == 8 || j == 12 || j == 16);
                if (e_chg) e_idx = e_idx + 3'd1;
                tick();
                check($sformatf("repeat_c%0d", j), 1, 0, e_idx, e_chg);
            end
        end
        set_in(0, 0, 0, 0, 0);
        for (int j = 0; j < 6; j++) begin
            tick();
            check("repeat_released", 1, 0, 3'd4, 0);
        end

        // Both held: no steps at all.
        set_in(0, 1, 1, 0, 0);
        for (int j = 0; j < 15; j++) begin
            tick();
            check("both_held", 1, 0, 3'd4, 0);
        end
        set_in(0, 0, 0, 0, 0);
        tick();
        check("both_released", 1, 0, 3'd4, 0);

        // Asynchronous reset mid-repeat.
        set_in(0, 1, 0, 0, 0);
        tick();
        check("mid_rep_first", 1, 0, 3'd0, 1);
        for (int j = 1; j < 10; j++) tick();
        check("mid_rep_after_delay", 1, 0, 3'd1, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset", 0, 0, 3'd1, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            tick();
            check("post_reset_hold", 0, 0, 3'd1, 0);
        end
        set_in(0, 0, 0, 0, 0);
        tick();
        check("post_reset_release", 0, 0, 3'd1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
